dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AM, default 11: word-address MSB, so the address width is AM:2.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4: consecutive store-denied cycles before a store is forced.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports ld_req (in, 1) and ld_addr (in, AM:2): load in the MEM stage requesting the data port, and its word address.
REQ-006 The block SHALL have ports ld_stall (out, 1), ld_rvalid (out, 1) and ld_data (out, 32): load held off this cycle; load data valid; load data.
REQ-007 The block SHALL have ports stq_mem_req (in, 1) and stq_mem_ack (out, 1): store-queue retirement request and grant.
REQ-008 The block SHALL have ports stq_mem_data (in, 32), stq_mem_addr (in, AM:2) and stq_mem_wenb (in, 4): the retiring store's data, address and byte enables.
REQ-009 The block SHALL have ports drain_req (in, 1) and drain_done (out, 1): fence request, and a one-cycle pulse when the store queue is empty.
REQ-010 The block SHALL have ports ram_en (out, 1), ram_we (out, 4), ram_addr (out, AM:2), ram_wdata (out, 32) and ram_rdata (in, 32): single-port synchronous SRAM.

Function
REQ-011 The FSM SHALL have three states: IDLE, FORCE and DRAIN.
REQ-012 In IDLE, the block SHALL give loads priority: stq_mem_ack = stq_mem_req & ~ld_req, and ld_stall = 0.
REQ-013 In FORCE and DRAIN, the block SHALL give stores priority: stq_mem_ack = stq_mem_req, and ld_stall = ld_req & stq_mem_req.
REQ-014 RAM drive: on a store grant the block SHALL drive ram_en=1, ram_we=stq_mem_wenb, ram_addr=stq_mem_addr, ram_wdata=stq_mem_data; on a load grant it SHALL drive ram_en=1, ram_we=0, ram_addr=ld_addr; otherwise ram_en=0 and ram_we=0.
REQ-015 A load is granted when ld_req & ~ld_stall; ld_rvalid SHALL be that grant registered, with ld_data = ram_rdata, giving one-cycle latency.
REQ-016 Starvation counter (width clog2(STARVE_MAX+1)): it SHALL increment while in IDLE with stq_mem_req & ~stq_mem_ack, SHALL clear on any stq_mem_ack, and SHALL saturate at STARVE_MAX.
REQ-017 The FSM SHALL move IDLE->FORCE when the counter equals STARVE_MAX and stq_mem_req=1.
REQ-018 The FSM SHALL move FORCE->IDLE after exactly one store grant; if stq_mem_req has dropped, it SHALL return to IDLE with no grant.
REQ-019 The FSM SHALL move from any state to DRAIN when drain_req=1; drain_req SHALL take precedence over the starvation transition.
REQ-020 The FSM SHALL move DRAIN->IDLE in the first DRAIN cycle with stq_mem_req=0; drain_done SHALL pulse high for that one cycle, registered, visible the following cycle.
REQ-021 If drain_req arrives with the store queue already empty, drain_done SHALL assert exactly 2 cycles after drain_req is sampled.
REQ-022 The block SHALL never grant a load and a store in the same cycle, and SHALL never drive ram_en with ram_we≠0 without stq_mem_ack.

Reset
REQ-023 Reset SHALL set state=IDLE, counter=0, ld_rvalid=0 and drain_done=0.
REQ-024 During and after reset, ram_en, ram_we and stq_mem_ack SHALL be 0 whenever stq_mem_req=0 and ld_req=0.
REQ-025 Reset asserted mid-FORCE or mid-DRAIN SHALL abandon the sequence without emitting drain_done.

Configuration
REQ-026 Macro DMEM_ARB_STARVE_EN defined: the counter and the FORCE state SHALL exist as specified.
REQ-027 DMEM_ARB_STARVE_EN undefined: the counter and FORCE SHALL be removed, IDLE SHALL be strict load priority, and STARVE_MAX SHALL be ignored; DRAIN is unaffected.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, FORCE=2'd1, DRAIN=2'd2) and the default STARVE_MAX constant.
REQ-029 The block SHALL be a single module with no sub-modules; the counter and FSM live in one registered process.

Verification
REQ-030 Bench SHALL cover: stq_mem_req=1 and ld_req=0 with addr 0x10, wenb 4'b0011 -> same-cycle stq_mem_ack=1, ram_we=4'b0011, ram_addr=0x10.
REQ-031 Bench SHALL cover: ld_req=1 at addr 0x20 with RAM holding 0xDEADBEEF -> ld_stall=0, and the next cycle ld_rvalid=1, ld_data=0xDEADBEEF.
REQ-032 Bench SHALL cover: ld_req and stq_mem_req held high, STARVE_MAX=4 -> acks denied for 4 cycles, then FORCE grants the store on cycle 5 with ld_stall=1, then IDLE and the counter returns to 0.
REQ-033 Bench SHALL cover: drain_req with 2 queued stores while ld_req=1 -> both stores granted on consecutive cycles, loads stalled, drain_done pulses once, then loads resume.
REQ-034 Bench SHALL cover: drain_req with stq_mem_req=0 -> drain_done=1 exactly 2 cycles later for 1 cycle.
REQ-035 Bench SHALL cover: reset asserted in DRAIN -> state=IDLE, drain_done never pulses, outputs quiescent.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared FSM state encoding and default anti-starvation threshold
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FORCE = 2'd1,
    DRAIN = 2'd2
  } state_e;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port SRAM between MEM-stage loads and store-queue retirement.
// Define DMEM_ARB_STARVE_EN to add the store starvation counter and the FORCE state.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AM         = 11,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AM:2]   ld_addr,
  output logic          ld_stall,
  output logic          ld_rvalid,
  output logic [31:0]   ld_data,
  input  logic          stq_mem_req,
  output logic          stq_mem_ack,
  input  logic [31:0]   stq_mem_data,
  input  logic [AM:2]   stq_mem_addr,
  input  logic [3:0]    stq_mem_wenb,
  input  logic          drain_req,
  output logic          drain_done,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AM:2]   ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  state_e state_q, state_d;
  logic   ld_rvalid_q, ld_rvalid_d, drain_done_q, drain_done_d, ld_gnt, store_pri, starved;

  if (STARVE_MAX < 1) begin : g_chk
    $error("STARVE_MAX must be at least 1");
  end

  assign store_pri = state_q != IDLE;

  always_comb begin
    stq_mem_ack = store_pri ? stq_mem_req : stq_mem_req & ~ld_req;
    ld_stall    = store_pri & ld_req & stq_mem_req;
    ld_gnt      = ld_req & ~ld_stall;
    ram_en      = stq_mem_ack | ld_gnt;
    ram_we      = stq_mem_ack ? stq_mem_wenb : 4'b0000;
    ram_addr    = stq_mem_ack ? stq_mem_addr : ld_addr;
    ram_wdata   = stq_mem_data;
    ld_rvalid_d = ld_gnt;
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Transition on the count being reached so the forced grant lands right after STARVE_MAX denials.
  always_comb begin
    cnt_d   = stq_mem_ack ? '0 :
              (state_q == IDLE && stq_mem_req && cnt_q != CW'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
    starved = stq_mem_req && cnt_d == CW'(STARVE_MAX);
  end
`else
  assign starved = 1'b0;
`endif

  // An empty queue ends a drain even if drain_req is still held, so a fence always completes.
  always_comb begin
    state_d      = (state_q == DRAIN) ? (stq_mem_req ? DRAIN : IDLE) :
                   drain_req          ? DRAIN :
                   (state_q == FORCE) ? IDLE :
                   starved            ? FORCE : state_q;
    drain_done_d = state_q == DRAIN && !stq_mem_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ld_rvalid_q  <= 1'b0;
      drain_done_q <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ld_rvalid_q  <= ld_rvalid_d;
      drain_done_q <= drain_done_d;
`ifdef DMEM_ARB_STARVE_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ld_rvalid  = ld_rvalid_q;
  assign ld_data    = ram_rdata;
  assign drain_done = drain_done_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural SRAM.
module tb_dmem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ld_req = 1'b0, stq_mem_req = 1'b0, drain_req = 1'b0;
  logic [11:2] ld_addr = '0, stq_mem_addr = '0;
  logic [31:0] stq_mem_data = '0;
  logic [3:0]  stq_mem_wenb = '0;
  logic        ld_stall, ld_rvalid, stq_mem_ack, drain_done, ram_en;
  logic [31:0] ld_data, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;
  logic [11:2] ram_addr;
  logic [31:0] mem [0:1023];
  int n_pass = 0, n_total = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_rvalid(ld_rvalid), .ld_data(ld_data),
    .stq_mem_req(stq_mem_req), .stq_mem_ack(stq_mem_ack), .stq_mem_data(stq_mem_data),
    .stq_mem_addr(stq_mem_addr), .stq_mem_wenb(stq_mem_wenb),
    .drain_req(drain_req), .drain_done(drain_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic lr, input logic [11:2] la, input logic sr, input logic [11:2] sa,
                       input logic [31:0] sd, input logic [3:0] sw, input logic dr);
    @(negedge clk);
    ld_req = lr; ld_addr = la; stq_mem_req = sr; stq_mem_addr = sa;
    stq_mem_data = sd; stq_mem_wenb = sw; drain_req = dr;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_rvalid", ld_rvalid, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ack", stq_mem_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    // store-only: same-cycle grant
    drive(0, 0, 1, 10'h10, 32'h12345678, 4'b0011, 0);
    chk("st_ack", stq_mem_ack, 1);
    chk("st_ram_en", ram_en, 1);
    chk("st_ram_we", ram_we, 4'b0011);
    chk("st_ram_addr", ram_addr, 32'h10);
    drive(0, 0, 1, 10'h20, 32'hDEADBEEF, 4'b1111, 0);
    chk("st2_ack", stq_mem_ack, 1);
    // load with one-cycle latency
    drive(1, 10'h20, 0, 0, 0, 0, 0);
    chk("ld_stall", ld_stall, 0);
    chk("ld_ram_we", ram_we, 0);
    chk("ld_ram_addr", ram_addr, 32'h20);
    drive(1, 10'h10, 0, 0, 0, 0, 0);
    chk("ld_rvalid", ld_rvalid, 1);
    chk("ld_data", ld_data, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ld_data_bytes", {16'h0, ld_data[15:0]}, 32'h5678);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ld_rvalid_drop", ld_rvalid, 0);
    chk("idle_ram_en", ram_en, 0);
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 1; i <= 10; i++) begin
      drive(1, 10'h20, 1, 10'h40, 32'hA5A5A5A5, 4'hF, 0);
      chk($sformatf("starve_ack_c%0d", i), stq_mem_ack, (i == 5 || i == 10) ? 1 : 0);
      chk($sformatf("starve_stall_c%0d", i), ld_stall, (i == 5 || i == 10) ? 1 : 0);
    end
    chk("force_ram_we", ram_we, 4'hF);
`else
    for (int i = 1; i <= 8; i++) begin
      drive(1, 10'h20, 1, 10'h40, 32'hA5A5A5A5, 4'hF, 0);
      chk($sformatf("prio_ack_c%0d", i), stq_mem_ack, 0);
      chk($sformatf("prio_stall_c%0d", i), ld_stall, 0);
    end
`endif
    // drain with two queued stores while loads keep requesting
    drive(1, 10'h20, 1, 10'h30, 32'h11111111, 4'hF, 1);
    chk("dr_a_ack", stq_mem_ack, 0);
    drive(1, 10'h20, 1, 10'h30, 32'h11111111, 4'hF, 0);
    chk("dr_b_ack", stq_mem_ack, 1);
    chk("dr_b_stall", ld_stall, 1);
    chk("dr_b_ram_addr", ram_addr, 32'h30);
    drive(1, 10'h20, 1, 10'h31, 32'h22222222, 4'hF, 0);
    chk("dr_c_ack", stq_mem_ack, 1);
    chk("dr_c_stall", ld_stall, 1);
    chk("dr_c_done", drain_done, 0);
    drive(1, 10'h20, 0, 0, 0, 0, 0);
    chk("dr_d_stall", ld_stall, 0);
    chk("dr_d_ram_we", ram_we, 0);
    chk("dr_d_done", drain_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("dr_e_done", drain_done, 1);
    chk("dr_e_rvalid", ld_rvalid, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("dr_f_done", drain_done, 0);
    // drain with an empty queue
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("de_a_done", drain_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("de_b_done", drain_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("de_c_done", drain_done, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("de_d_done", drain_done, 0);
    // reset in the middle of a drain
    drive(0, 0, 1, 10'h50, 32'h33333333, 4'hF, 1);
    chk("rd_a_ack", stq_mem_ack, 1);
    drive(1, 10'h20, 1, 10'h51, 32'h44444444, 4'hF, 0);
    chk("rd_b_stall", ld_stall, 1);
    #2;
    reset = 1'b1;
    ld_req = 1'b0;
    stq_mem_req = 1'b0;
    #1;
    chk("rd_rst_ram_en", ram_en, 0);
    chk("rd_rst_ack", stq_mem_ack, 0);
    chk("rd_rst_done", drain_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rd_rst_done2", drain_done, 0);
    chk("rd_rst_ram_we", ram_we, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("rd_post_done_%0d", i), drain_done, 0);
      chk($sformatf("rd_post_ram_en_%0d", i), ram_en, 0);
    end
    drive(1, 10'h20, 1, 10'h52, 32'h55555555, 4'hF, 0);
    chk("rd_idle_ack", stq_mem_ack, 0);
    chk("rd_idle_stall", ld_stall, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
